// File: rtl/effective_address_unit.sv
// -----------------------------------------------------------------------------
// effective_address_unit
//
// Resolves the PDP-8 memory-reference effective address (EA) of a decoded
// instruction. Direct addresses resolve locally. Indirect addresses fetch the
// pointer word through the memory_controller read/write handshake. Auto-index
// words are optionally incremented and written back through the same handshake.
//
// Optional feature macro: EA_AUTOINDEX_EN
//   defined     : locations AUTOINDEX_BASE..AUTOINDEX_BASE+7 are
//                 pre-incremented on indirect use, and the new value is
//                 written back.
//   not defined : auto-index words behave as plain indirect words. No write is
//                 ever issued.
//
// Ports
//   clk              in   system clock, all state changes on posedge
//   reset            in   asynchronous, active-high; clears all state/outputs
//   start            in   request an EA computation (sampled only when idle)
//   instruction[11:0] in  IR: [8]=I indirect, [7]=Z current page, [6:0]=offset
//   pc[11:0]         in   instruction address (supplies page bits)
//   busy             out  high from accepting edge until ea_valid drops
//   ea_valid         out  one-cycle pulse qualifying ea
//   ea[11:0]         out  effective address, held until next ea_valid
//   mem_address      out  to bus.address
//   mem_write_data   out  to bus.write_data
//   mem_read_enable  out  to bus.read_enable
//   mem_write_enable out  to bus.write_enable
//   read_type        out  to controller read_type, constant DATA_READ
//   mem_read_data    in   from bus.read_data
//   mem_finished     in   from bus.mem_finished
// -----------------------------------------------------------------------------

`ifndef DATA_READ
`define DATA_READ 1'b0
`endif

module effective_address_unit #(
    parameter logic [11:0] AUTOINDEX_BASE = 12'o0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] instruction,
    input  logic [11:0] pc,
    output logic        busy,
    output logic        ea_valid,
    output logic [11:0] ea,
    output logic [11:0] mem_address,
    output logic [11:0] mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic        read_type,
    input  logic [11:0] mem_read_data,
    input  logic        mem_finished
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        RD          = 3'd1,
        DONE        = 3'd2,
        DIRECT_DONE = 3'd3
`ifdef EA_AUTOINDEX_EN
        ,
        AI_WR       = 3'd4
`endif
    } state_t;

    state_t      state_r, state_next_s;
    logic        busy_r, busy_next_s;
    logic        ea_valid_r, ea_valid_next_s;
    logic [11:0] ea_r, ea_next_s;
    logic [11:0] mem_address_r, mem_address_next_s;
    logic        mem_read_enable_r, mem_read_enable_next_s;
    logic [11:0] ptr_r, ptr_next_s;
    logic [11:0] da_s;
    logic        unused_s;

`ifdef EA_AUTOINDEX_EN
    logic [11:0] da_r, da_next_s;
    logic [11:0] mem_write_data_r, mem_write_data_next_s;
    logic        mem_write_enable_r, mem_write_enable_next_s;

    // 12-bit increment; 0o7777 wraps to 0o0000.
    function automatic logic [11:0] incr12(input logic [11:0] value);
        return value + 12'd1;
    endfunction

    // True when addr lies in the eight-word auto-index window.
    function automatic logic is_autoindex(input logic [11:0] addr);
        logic [11:0] diff;
        diff = addr - AUTOINDEX_BASE;
        return (diff < 12'd8);
    endfunction
`endif

    // Direct address: zero page or current page selected by Z.
    assign da_s = instruction[7] ? {pc[11:7], instruction[6:0]}
                                 : {5'b00000, instruction[6:0]};

    // Instruction opcode bits and the low pc bits do not take part in address formation.
`ifdef EA_AUTOINDEX_EN
    assign unused_s = ^{instruction[11:9], pc[6:0]};
`else
    assign unused_s = ^{instruction[11:9], pc[6:0], AUTOINDEX_BASE};
`endif

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        state_next_s           = state_r;
        busy_next_s            = busy_r;
        ea_valid_next_s        = 1'b0;
        ea_next_s              = ea_r;
        mem_address_next_s     = mem_address_r;
        mem_read_enable_next_s = mem_read_enable_r;
        ptr_next_s             = ptr_r;
`ifdef EA_AUTOINDEX_EN
        da_next_s               = da_r;
        mem_write_data_next_s   = mem_write_data_r;
        mem_write_enable_next_s = mem_write_enable_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    busy_next_s = 1'b1;
`ifdef EA_AUTOINDEX_EN
                    da_next_s   = da_s;
`endif
                    if (instruction[8]) begin
                        state_next_s           = RD;
                        mem_read_enable_next_s = 1'b1;
                        mem_address_next_s     = da_s;
                    end else begin
                        state_next_s    = DIRECT_DONE;
                        ea_valid_next_s = 1'b1;
                        ea_next_s       = da_s;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                if (mem_finished) begin
                    // Dropping the enable here means the controller, now leaving DONE, sees it low.
                    mem_read_enable_next_s = 1'b0;
                    ptr_next_s             = mem_read_data;
`ifdef EA_AUTOINDEX_EN
                    if (is_autoindex(da_r)) begin
                        state_next_s            = AI_WR;
                        mem_write_enable_next_s = 1'b1;
                        mem_write_data_next_s   = incr12(mem_read_data);
                    end else begin
                        state_next_s    = DONE;
                        ea_valid_next_s = 1'b1;
                        ea_next_s       = ptr_next_s;
                    end
`else
                    state_next_s    = DONE;
                    ea_valid_next_s = 1'b1;
                    ea_next_s       = ptr_next_s;
`endif
                end else begin
                    state_next_s = RD;
                end
            end
`ifdef EA_AUTOINDEX_EN
            AI_WR: begin
                if (mem_finished) begin
                    mem_write_enable_next_s = 1'b0;
                    state_next_s            = DONE;
                    ea_valid_next_s         = 1'b1;
                    ea_next_s               = incr12(ptr_r);
                end else begin
                    state_next_s = AI_WR;
                end
            end
`endif
            DONE, DIRECT_DONE: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
            default: begin
                state_next_s           = IDLE;
                busy_next_s            = 1'b0;
                mem_read_enable_next_s = 1'b0;
`ifdef EA_AUTOINDEX_EN
                mem_write_enable_next_s = 1'b0;
`endif
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            busy_r            <= 1'b0;
            ea_valid_r        <= 1'b0;
            ea_r              <= 12'd0;
            mem_address_r     <= 12'd0;
            mem_read_enable_r <= 1'b0;
            ptr_r             <= 12'd0;
        end else begin
            state_r           <= state_next_s;
            busy_r            <= busy_next_s;
            ea_valid_r        <= ea_valid_next_s;
            ea_r              <= ea_next_s;
            mem_address_r     <= mem_address_next_s;
            mem_read_enable_r <= mem_read_enable_next_s;
            ptr_r             <= ptr_next_s;
        end
    end

`ifdef EA_AUTOINDEX_EN
    // Auto-index write-back registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            da_r               <= 12'd0;
            mem_write_data_r   <= 12'd0;
            mem_write_enable_r <= 1'b0;
        end else begin
            da_r               <= da_next_s;
            mem_write_data_r   <= mem_write_data_next_s;
            mem_write_enable_r <= mem_write_enable_next_s;
        end
    end

    assign mem_write_data   = mem_write_data_r;
    assign mem_write_enable = mem_write_enable_r;
`else
    assign mem_write_data   = 12'd0;
    assign mem_write_enable = 1'b0;
`endif

    assign busy            = busy_r;
    assign ea_valid        = ea_valid_r;
    assign ea              = ea_r;
    assign mem_address     = mem_address_r;
    assign mem_read_enable = mem_read_enable_r;
    assign read_type       = `DATA_READ;

endmodule

// File: tb/tb_effective_address_unit.sv
// -----------------------------------------------------------------------------
// tb_effective_address_unit
//
// Bench for effective_address_unit. A memory_controller model with a
// programmable extra latency drives the handshake. A reference model works
// out the PDP-8 address rules and predicts the EA, the latency from the
// accepting edge, and the memory side effects. It handles both settings of
// EA_AUTOINDEX_EN.
// -----------------------------------------------------------------------------
module tb_effective_address_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] instruction = 12'd0;
    logic [11:0] pc = 12'd0;
    logic        busy, ea_valid, mem_read_enable, mem_write_enable, read_type;
    logic [11:0] ea, mem_address, mem_write_data;
    logic [11:0] mem_read_data = 12'd0;
    logic        mem_finished = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ctrl_delay = 0;

    logic [11:0] mem     [0:4095];
    logic [11:0] ref_mem [0:4095];

    effective_address_unit dut (
        .clk(clk), .reset(reset), .start(start), .instruction(instruction), .pc(pc),
        .busy(busy), .ea_valid(ea_valid), .ea(ea), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_enable(mem_read_enable),
        .mem_write_enable(mem_write_enable), .read_type(read_type),
        .mem_read_data(mem_read_data), .mem_finished(mem_finished)
    );

    always #5 clk = ~clk;

    // memory_controller model: IDLE -> READ/WRITE (1+ctrl_delay cycles) -> DONE -> IDLE.
    // It has no reset, like the real controller.
    int          c_state = 0;
    int          c_cnt = 0;
    logic [11:0] c_addr = 12'd0;
    always @(posedge clk) begin
        case (c_state)
            0: if (mem_read_enable || mem_write_enable) begin
                   c_state <= 1;
                   c_addr  <= mem_address;
                   c_cnt   <= ctrl_delay;
                   if (mem_write_enable) mem[mem_address] = mem_write_data;
               end
            1: if (c_cnt == 0) begin
                   c_state       <= 2;
                   mem_finished  <= 1'b1;
                   mem_read_data <= mem[c_addr];
               end else begin
                   c_cnt <= c_cnt - 1;
               end
            default: begin
                c_state      <= 0;
                mem_finished <= 1'b0;
            end
        endcase
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    function automatic bit model_autoindex_on();
`ifdef EA_AUTOINDEX_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic poke(input logic [11:0] addr, input logic [11:0] value);
        mem[addr]     = value;
        ref_mem[addr] = value;
    endtask

    // Issue one request, then observe it for 40 cycles against the reference model.
    task automatic run_req(input logic [11:0] instr, input logic [11:0] pcv,
                           input int dly, input bit glitch, input string tag);
        logic [11:0] da, exp_ea, got_ea;
        int          exp_lat, lat, pulses, overlap;
        bit          ind, ai, rd_seen, wr_seen;
        int          page, off;

        for (int w = 0; w < 100 && busy; w++) @(negedge clk);
        check_value({tag, ":idle_wait"}, {31'd0, busy}, 32'd0);

        // Reference: page arithmetic on integers.
        off  = int'(instr) % 128;
        page = int'(pcv) / 128;
        da   = ((instr / 12'd128) % 12'd2 == 12'd1) ? 12'(page * 128 + off) : 12'(off);
        ind  = ((instr / 12'd256) % 12'd2) == 12'd1;
        ai   = ind && model_autoindex_on() && (int'(da) >= 8) && (int'(da) <= 15);
        if (!ind) begin
            exp_ea  = da;
            exp_lat = 0;
        end else if (ai) begin
            exp_ea      = 12'((int'(ref_mem[da]) + 1) % 4096);
            ref_mem[da] = exp_ea;
            exp_lat     = 6 + 2 * dly;
        end else begin
            exp_ea  = ref_mem[da];
            exp_lat = 3 + dly;
        end

        ctrl_delay = dly;
        @(negedge clk);
        start = 1'b1; instruction = instr; pc = pcv;
        @(posedge clk);
        lat = -1; pulses = 0; overlap = 0; rd_seen = 0; wr_seen = 0; got_ea = 12'd0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (glitch && k == 0) begin
                start = 1'b1; instruction = 12'o1005; pc = 12'o0000;
            end else begin
                start = 1'b0;
            end
            if (mem_read_enable && mem_write_enable) overlap++;
            if (mem_read_enable) rd_seen = 1'b1;
            if (mem_write_enable) wr_seen = 1'b1;
            if (ea_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    got_ea = ea;
                end
            end
        end
        check_value({tag, ":ea"}, {20'd0, got_ea}, {20'd0, exp_ea});
        check_value({tag, ":latency"}, lat, exp_lat);
        check_value({tag, ":pulses"}, pulses, 1);
        check_value({tag, ":overlap"}, overlap, 0);
        check_value({tag, ":read_issued"}, {31'd0, rd_seen}, {31'd0, ind});
        check_value({tag, ":write_issued"}, {31'd0, wr_seen}, {31'd0, ai});
        check_value({tag, ":mem_word"}, {20'd0, mem[da]}, {20'd0, ref_mem[da]});
        check_value({tag, ":ea_hold"}, {20'd0, ea}, {20'd0, exp_ea});
        check_value({tag, ":busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int pulses;
        logic [11:0] instr, pcv;
        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 12'd0;
            ref_mem[i] = 12'd0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check_value("rst:busy", {31'd0, busy}, 32'd0);
        check_value("rst:ea_valid", {31'd0, ea_valid}, 32'd0);
        check_value("rst:ea", {20'd0, ea}, 32'd0);
        check_value("rst:addr", {20'd0, mem_address}, 32'd0);
        check_value("rst:enables", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases.
        run_req(12'o1012, 12'o0345, 0, 1'b0, "zero_page_direct");
        run_req(12'o1212, 12'o0345, 0, 1'b0, "current_page_direct");
        poke(12'o0020, 12'o4321);
        run_req(12'o1420, 12'o0345, 0, 1'b0, "plain_indirect");
        poke(12'o0012, 12'o7777);
        run_req(12'o1412, 12'o0345, 0, 1'b0, "autoindex_wrap");
        run_req(12'o1612, 12'o0100, 1, 1'b0, "cur_page_autoindex");
        run_req(12'o1420, 12'o0345, 0, 1'b1, "start_while_busy");
        run_req(12'o1420, 12'o0345, 3, 1'b0, "slow_controller");

        // Reset one cycle after acceptance of an indirect request.
        @(negedge clk);
        start = 1'b1; instruction = 12'o1420; pc = 12'o0345;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_value("midrst:busy", {31'd0, busy}, 32'd0);
        check_value("midrst:ea", {20'd0, ea}, 32'd0);
        check_value("midrst:addr", {20'd0, mem_address}, 32'd0);
        check_value("midrst:enables", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ea_valid || mem_read_enable) pulses++;
        end
        check_value("midrst:no_activity", pulses, 0);
        run_req(12'o1212, 12'o0345, 0, 1'b0, "after_reset_direct");

        // Randomized requests, biased toward the auto-index window.
        for (int n = 0; n < 40; n++) begin
            instr = 12'($urandom_range(0, 4095));
            pcv   = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 2) == 0) begin
                instr[6:0] = 7'($urandom_range(8, 15));
                if ($urandom_range(0, 1) == 1) pcv[11:7] = 5'd0;
            end
            if ($urandom_range(0, 1) == 1)
                poke(instr[7] ? {pcv[11:7], instr[6:0]} : {5'd0, instr[6:0]},
                     12'($urandom_range(0, 4095)));
            run_req(instr, pcv, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/effective_address_unit.md
# effective_address_unit

Computes the PDP-8 memory-reference effective address (EA) for a decoded instruction and sits directly upstream of `memory_controller`. It issues the indirect pointer read, and the auto-index write-back when needed, over the controller's read/write handshake. It then hands a 12-bit EA to the execute stage. Direct addresses resolve without a memory access.

## Interface
- `AUTOINDEX_BASE`, default 12'o0010: first of eight auto-index words (0o0010–0o0017).
- `clk` in 1: system clock; all state changes on posedge.
- `reset` in 1: asynchronous, active-high. Clears all state and outputs.
- `start` in 1: request an EA computation. Sampled only when `busy`=0.
- `instruction` in 12: IR. `[8]`=I (indirect), `[7]`=Z (1 = current page), `[6:0]`=offset.
- `pc` in 12: address of the instruction; supplies the page bits.
- `busy` out 1: high from the accepting edge until `ea_valid` drops.
- `ea_valid` out 1: one-cycle pulse; `ea` is valid while it is high.
- `ea` out 12: effective address; holds its value until the next `ea_valid`.
- `mem_address` out 12: to `bus.address`.
- `mem_write_data` out 12: to `bus.write_data`.
- `mem_read_enable` out 1: to `bus.read_enable`.
- `mem_write_enable` out 1: to `bus.write_enable`.
- `read_type` out 1: to the controller's `read_type`. Constant `` `DATA_READ ``.
- `mem_read_data` in 12: from `bus.read_data`.
- `mem_finished` in 1: from `bus.mem_finished`.

## Operation
- Direct address `da` = Z ? {pc[11:7], offset} : {5'b0, offset}. Captured on the `start` edge.
- States:
  - IDLE → DIRECT_DONE when I=0.
  - IDLE → RD when I=1.
  - RD → AI_WR when `mem_finished` is seen and `da` is auto-index.
  - RD → DONE when `mem_finished` is seen and `da` is not auto-index.
  - AI_WR → DONE on `mem_finished`.
  - DONE / DIRECT_DONE → IDLE.
- RD:
  - `mem_read_enable`=1 and `mem_address`=`da`.
  - On `mem_finished`, register `ptr` = `mem_read_data`.
- AI_WR:
  - `mem_write_enable`=1, `mem_address`=`da`, `mem_write_data`=`ptr+1` (mod 2^12; 0o7777 → 0o0000).
- `ea` loaded values:
  - DIRECT_DONE: `ea`=`da`.
  - Non-auto-index DONE: `ea`=`ptr`.
  - Auto-index DONE: `ea`=`ptr+1`.
- Auto-index test: `da` in [AUTOINDEX_BASE, AUTOINDEX_BASE+7] and I=1. It applies whether Z is 0 or 1, because the full 12-bit `da` is compared.
- All outputs are registered. Read and write enables are never high in the same cycle.
- Each enable deasserts on the edge where `mem_finished` is sampled. The controller is then leaving DONE, so no transaction is re-triggered.
- `mem_finished` is ignored in IDLE, DONE and DIRECT_DONE.
- `start` while `busy`=1 is ignored; no queuing.
- Reset values: state IDLE, `busy`=0, `ea_valid`=0, `ea`=0, `mem_address`=0, `mem_write_data`=0, both enables 0, `ptr`=0.
- Reset mid-operation:
  - Enables drop immediately and no `ea_valid` is produced.
  - A transaction the controller has already entered (READ or WRITE) still completes, because the controller has no reset.
  - A new `start` within 3 cycles of such a reset is unsupported.

## Timing
Edge E0 is the edge on which `start` is accepted.
- Direct: `ea_valid` high E0–E1.
- Indirect:
  - Read enable high E0–E3.
  - Controller in READ E1–E2 and DONE E2–E3.
  - `ea_valid` high E3–E4, 3 cycles after E0.
- Auto-index:
  - Read as above.
  - Write enable high E3–E6.
  - `ea_valid` high E6–E7.
- `busy` drops on the edge after `ea_valid`. Back-to-back `start` is accepted on that edge.
- If the controller is slower, latency stretches. The enable is held until `mem_finished`.

## Configuration
- `EA_AUTOINDEX_EN` defined: auto-index behaviour as above.
- `EA_AUTOINDEX_EN` not defined:
  - AI_WR is not built and no write is ever issued.
  - Auto-index words behave as plain indirect.
  - `mem_write_enable` is tied 0 and `mem_write_data` is tied 0.

## Test plan
- Zero-page direct: `instruction`=0o1012, `pc`=0o0345 → `ea_valid` E0–E1, `ea`=0o0012, no memory enables.
- Current-page direct: `instruction`=0o1212, `pc`=0o0345 → `ea`=0o0212 after 1 cycle.
- Plain indirect: `instruction`=0o1420, mem[0o0020]=0o4321 → `mem_address`=0o0020, `ea`=0o4321 at E3, no write, mem[0o0020] unchanged.
- Auto-index wrap (macro on): `instruction`=0o1412, mem[0o0012]=0o7777 → mem[0o0012] becomes 0o0000, `ea`=0o0000 at E6. With the macro off: `ea`=0o7777 at E3 and mem[0o0012] unchanged.
- `start` pulsed while `busy` during an indirect read → ignored, exactly one `ea_valid`, `ea` from the first request.
- `reset` asserted in the cycle after E0 of an indirect request → all outputs 0 immediately, state IDLE, no `ea_valid`. A new direct request issued 4 cycles later returns the correct `ea`.
